// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the AD9228 channel readers.
// Arms on command, waits for a software or external trigger, applies a
// post-trigger delay, then asserts the masked FIFO write enables for
// exactly num_samples sample-clock cycles. Runs in the ADC sample clock domain.
module adc_capture_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              sw_trig,
  input  logic              ext_trig,
  input  logic              ext_trig_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [CNT_W-1:0]  trig_delay,
  input  logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] fifo_wr_en,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // External trigger conditioning
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ext_last;
  logic                   r_ext_evt;

  // Latched configuration
  logic [NUM_CH-1:0] r_mask_q;
  logic [CNT_W-1:0]  r_num_q;
  logic [CNT_W-1:0]  r_dly_q;

  // Counters and status
  logic [CNT_W-1:0]  r_dly_cnt;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic              r_done;
  logic              r_overflow;
  logic              r_armed;
  logic              r_busy;

  // Control strobes from the next-state logic
  logic              w_trig;
  logic              w_latch_cfg;
  logic              w_zero_len;
  logic              w_load_dly;
  logic              w_cap_cyc;
  logic              w_finish;
  logic              w_ovf_hit;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_trig     = sw_trig | (ext_trig_en & r_ext_evt);
  assign w_zero_len = (num_samples == '0);
  assign w_cnt_inc  = r_sample_cnt + CNT_W'(1);
  assign w_ovf_hit  = w_cap_cyc & (|(r_mask_q & fifo_full));

  // Synchronise ext_trig and produce a registered one-cycle rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_ext_last <= 1'b0;
      r_ext_evt  <= 1'b0;
    end else begin
      r_sync     <= SYNC_STAGES'({r_sync, ext_trig});
      r_ext_last <= r_sync[SYNC_STAGES-1];
      r_ext_evt  <= r_sync[SYNC_STAGES-1] & ~r_ext_last;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_latch_cfg = 1'b0;
    w_load_dly  = 1'b0;
    w_cap_cyc   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          w_latch_cfg = 1'b1;
          w_state_nxt = w_zero_len ? S_DONE : S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_trig) begin
          w_load_dly  = 1'b1;
          w_state_nxt = (r_dly_q == '0) ? S_CAPTURE : S_DELAY;
        end
      end
      S_DELAY: begin
        if (r_dly_cnt == '0) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_cap_cyc = 1'b1;
        if (w_cnt_inc == r_num_q) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_latch_cfg = 1'b0;
      w_load_dly  = 1'b0;
      w_finish    = 1'b0;
    end
  end

  // Configuration latch on an accepted arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_q <= '0;
      r_num_q  <= '0;
      r_dly_q  <= '0;
    end else if (w_latch_cfg) begin
      r_mask_q <= ch_mask;
      r_num_q  <= num_samples;
      r_dly_q  <= trig_delay;
    end
  end

  // Post-trigger delay counter: loaded with delay-1, counts down in DELAY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly_cnt <= '0;
    end else if (w_load_dly) begin
      r_dly_cnt <= r_dly_q - CNT_W'(1);
    end else if (r_state == S_DELAY) begin
      r_dly_cnt <= r_dly_cnt - CNT_W'(1);
    end
  end

  // Sample counter and sticky done/overflow status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_latch_cfg) begin
      r_sample_cnt <= '0;
      r_done       <= w_zero_len;
      r_overflow   <= 1'b0;
    end else begin
      if (w_cap_cyc) begin
        r_sample_cnt <= w_cnt_inc;
      end
      if (w_ovf_hit) begin
        r_overflow <= 1'b1;
      end
      if (w_finish) begin
        r_done <= 1'b1;
      end
    end
  end

  // Registered state-decode flags, aligned with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_armed <= (w_state_nxt == S_ARMED);
      r_busy  <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_DELAY) ||
                 (w_state_nxt == S_CAPTURE);
    end
  end

  // Write enables follow fifo_full combinationally so a full channel is skipped
  always_comb begin
    fifo_wr_en = '0;
    if (r_state == S_CAPTURE) begin
      fifo_wr_en = r_mask_q & ~fifo_full;
    end
  end

  assign armed      = r_armed;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: per-cycle write-enable expectations
// are queued when a capture is launched and popped as the capture runs.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              arm;
  logic              abort;
  logic              sw_trig;
  logic              ext_trig;
  logic              ext_trig_en;
  logic [NUM_CH-1:0] ch_mask;
  logic [CNT_W-1:0]  num_samples;
  logic [CNT_W-1:0]  trig_delay;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_wr_en;
  logic              armed;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [CNT_W-1:0]  sample_cnt;

  int checks   = 0;
  int failures = 0;

  logic [NUM_CH-1:0] exp_q[$];
  logic [NUM_CH-1:0] full_q[$];

  adc_capture_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .sw_trig(sw_trig),
    .ext_trig(ext_trig), .ext_trig_en(ext_trig_en), .ch_mask(ch_mask),
    .num_samples(num_samples), .trig_delay(trig_delay), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .armed(armed), .busy(busy), .done(done),
    .overflow(overflow), .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [3:0] m, input logic [15:0] n, input logic [15:0] d);
    arm = 1'b1; ch_mask = m; num_samples = n; trig_delay = d;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 0; abort = 0; sw_trig = 0; ext_trig = 0; ext_trig_en = 0;
    ch_mask = '0; num_samples = '0; trig_delay = '0; fifo_full = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fifo_wr_en, armed, busy, done, overflow} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000000", {fifo_wr_en, armed, busy, done, overflow});
    end
    checks++;
    if (sample_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d expected 0", sample_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sw_trigger();
    logic [3:0] e;
    do_arm(4'b0101, 16'd8, 16'd0);
    #1;
    checks++;
    if ({armed, busy, fifo_wr_en} !== 6'b11_0000) begin
      failures++;
      $display("FAIL sw_armed: got %b expected 110000", {armed, busy, fifo_wr_en});
    end
    sw_trig = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(4'b0101);
    exp_q.push_back(4'b0000);
    for (int k = 1; k <= 9; k++) begin
      step();
      sw_trig = 1'b0;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (fifo_wr_en !== e) begin
        failures++;
        $display("FAIL sw_wr_en cycle %0d: got %b expected %b", k, fifo_wr_en, e);
      end
      if (k == 8) begin
        checks++;
        if ({done, busy} !== 2'b01) begin
          failures++;
          $display("FAIL sw_last_cycle: done/busy got %b expected 01", {done, busy});
        end
      end
      if (k == 9) begin
        checks++;
        if ({done, busy, armed} !== 3'b100 || sample_cnt !== 16'd8) begin
          failures++;
          $display("FAIL sw_done: done/busy/armed got %b cnt %0d expected 100 cnt 8", {done, busy, armed}, sample_cnt);
        end
      end
    end
  endtask

  task automatic test_ext_delay();
    logic [3:0] e;
    ext_trig_en = 1'b1;
    do_arm(4'b1111, 16'd3, 16'd5);
    #1;
    ext_trig = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(4'b0000);
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    for (int k = 1; k <= 12; k++) begin
      step();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (fifo_wr_en !== e) begin
        failures++;
        $display("FAIL ext_wr_en cycle %0d: got %b expected %b", k, fifo_wr_en, e);
      end
      if (k == 5) begin
        checks++;
        if ({armed, busy} !== 2'b01) begin
          failures++;
          $display("FAIL ext_in_delay: armed/busy got %b expected 01", {armed, busy});
        end
      end
      if (k == 12) begin
        checks++;
        if (done !== 1'b1 || sample_cnt !== 16'd3) begin
          failures++;
          $display("FAIL ext_done: done %b cnt %0d expected 1 cnt 3", done, sample_cnt);
        end
      end
    end
    ext_trig = 1'b0;
    ext_trig_en = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_overflow();
    logic [3:0] e;
    logic [3:0] f;
    do_arm(4'b0011, 16'd10, 16'd0);
    #1;
    sw_trig = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      f = (k == 2) ? 4'b0100 : ((k == 4 || k == 5) ? 4'b0001 : 4'b0000);
      full_q.push_back(f);
      exp_q.push_back(4'b0011 & ~f);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      sw_trig = 1'b0;
      fifo_full = full_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (fifo_wr_en !== e) begin
        failures++;
        $display("FAIL ovf_wr_en cycle %0d: got %b expected %b", k, fifo_wr_en, e);
      end
      if (k == 4) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_unmasked_full: overflow got %b expected 0", overflow);
        end
      end
      if (k == 5) begin
        checks++;
        if (overflow !== 1'b1) begin
          failures++;
          $display("FAIL ovf_set: overflow got %b expected 1", overflow);
        end
      end
    end
    step();
    fifo_full = '0;
    #1;
    checks++;
    if ({done, overflow, busy} !== 3'b110 || sample_cnt !== 16'd10 || fifo_wr_en !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_done: done/ovf/busy %b cnt %0d wr %b expected 110 cnt 10 wr 0000",
               {done, overflow, busy}, sample_cnt, fifo_wr_en);
    end
  endtask

  task automatic test_abort();
    logic [3:0] e;
    do_arm(4'b1111, 16'd10, 16'd0);
    #1;
    sw_trig = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1111);
    for (int k = 1; k <= 4; k++) begin
      step();
      sw_trig = 1'b0;
      if (k == 4) abort = 1'b1;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (fifo_wr_en !== e) begin
        failures++;
        $display("FAIL abort_wr_en cycle %0d: got %b expected %b", k, fifo_wr_en, e);
      end
    end
    step();
    abort = 1'b0;
    #1;
    checks++;
    if ({fifo_wr_en, busy, done, armed} !== 7'b0000_000 || sample_cnt !== 16'd4) begin
      failures++;
      $display("FAIL abort_state: wr/busy/done/armed %b cnt %0d expected 0000000 cnt 4",
               {fifo_wr_en, busy, done, armed}, sample_cnt);
    end
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({busy, fifo_wr_en} !== 5'b0_0000) begin
        failures++;
        $display("FAIL idle_trig cycle %0d: busy/wr got %b expected 00000", k, {busy, fifo_wr_en});
      end
      step();
    end
    arm = 1'b1; abort = 1'b1; num_samples = 16'd3;
    step();
    arm = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if ({armed, busy} !== 2'b00 || sample_cnt !== 16'd4) begin
      failures++;
      $display("FAIL abort_beats_arm: armed/busy %b cnt %0d expected 00 cnt 4", {armed, busy}, sample_cnt);
    end
  endtask

  task automatic test_zero_rearm();
    logic [3:0] e;
    do_arm(4'b1111, 16'd0, 16'd0);
    #1;
    checks++;
    if ({done, busy, armed} !== 3'b100 || sample_cnt !== 16'd0) begin
      failures++;
      $display("FAIL zero_len: done/busy/armed %b cnt %0d expected 100 cnt 0", {done, busy, armed}, sample_cnt);
    end
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    #1;
    checks++;
    if ({fifo_wr_en, done} !== 5'b0000_1) begin
      failures++;
      $display("FAIL zero_no_write: wr/done %b expected 00001", {fifo_wr_en, done});
    end
    arm = 1'b1; sw_trig = 1'b1; ch_mask = 4'b1000; num_samples = 16'd4; trig_delay = 16'd0;
    step();
    arm = 1'b0; sw_trig = 1'b0;
    #1;
    checks++;
    if ({done, armed} !== 2'b01) begin
      failures++;
      $display("FAIL rearm: done/armed %b expected 01", {done, armed});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      checks++;
      if ({armed, fifo_wr_en} !== 5'b1_0000) begin
        failures++;
        $display("FAIL arm_trig_same_cycle %0d: armed/wr %b expected 10000", k, {armed, fifo_wr_en});
      end
    end
    sw_trig = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0000);
    for (int k = 1; k <= 5; k++) begin
      step();
      sw_trig = 1'b0;
      if (k == 2) begin
        arm = 1'b1;
        num_samples = 16'd1;
      end else begin
        arm = 1'b0;
      end
      #1;
      e = exp_q.pop_front();
      checks++;
      if (fifo_wr_en !== e) begin
        failures++;
        $display("FAIL rearm_wr_en cycle %0d: got %b expected %b", k, fifo_wr_en, e);
      end
      if (k == 5) begin
        checks++;
        if (done !== 1'b1 || sample_cnt !== 16'd4) begin
          failures++;
          $display("FAIL rearm_done: done %b cnt %0d expected 1 cnt 4", done, sample_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid_delay();
    logic seen;
    do_arm(4'b1111, 16'd5, 16'd20);
    #1;
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    step();
    #1;
    checks++;
    if ({armed, busy} !== 2'b01) begin
      failures++;
      $display("FAIL in_delay: armed/busy %b expected 01", {armed, busy});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_wr_en, armed, busy, done, overflow} !== 8'h00 || sample_cnt !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: flags %b cnt %0d expected 00000000 cnt 0",
               {fifo_wr_en, armed, busy, done, overflow}, sample_cnt);
    end
    #2;
    rst = 1'b0;
    step();
    #1;
    checks++;
    if ({armed, busy} !== 2'b00) begin
      failures++;
      $display("FAIL after_reset: armed/busy %b expected 00", {armed, busy});
    end
    sw_trig = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      sw_trig = 1'b0;
      #1;
      if (fifo_wr_en !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: activity seen %b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_sw_trigger();
    test_ext_delay();
    test_overflow();
    test_abort();
    test_zero_rearm();
    test_reset_mid_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
